// File: rtl/tinyrisc_pkg.sv
// -----------------------------------------------------------------------------
// tinyrisc_pkg
//   Shared defaults for the tinyrisc front end and the {pc, inst} entry layout
//   that the fetch queue buffers for decode.
//   No ports; import with "import tinyrisc_pkg::*;".
// -----------------------------------------------------------------------------
package tinyrisc_pkg;

   localparam int          DEF_XLEN       = 32;
   localparam int          DEF_INST_BYTES = 4;
   localparam int          DEF_FQ_DEPTH   = 4;
   localparam logic [31:0] DEF_RESET_PC   = 32'h0000_0000;

   // One queued fetch: the PC sits in the upper half so that a flat
   // {pc, inst} vector and this struct share the same bit layout.
   typedef struct packed {
      logic [DEF_XLEN-1:0] pc;
      logic [DEF_XLEN-1:0] inst;
   } fetch_entry_t;

endpackage : tinyrisc_pkg

// File: rtl/fetch_fifo.sv
// -----------------------------------------------------------------------------
// fetch_fifo
//   Circular FIFO holding fetched {pc, inst} entries for decode.
//   Ports:
//     clk        in   clock, state updates on the falling edge
//     reset      in   asynchronous active-low reset
//     push       in   write push_data at the tail this edge
//     push_data  in   WIDTH-bit entry
//     pop        in   remove the head this edge (ignored while empty)
//     flush      in   discard all entries (wins over push/pop)
//     count      out  occupancy, 0..DEPTH
//     head_valid out  count != 0
//     head_data  out  head entry, reads 0 while empty
//   The caller must never push while full; the fetch unit's credit check
//   guarantees that.
// -----------------------------------------------------------------------------
module fetch_fifo #(
   parameter int DEPTH = 4,
   parameter int WIDTH = 64
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic                       push,
   input  logic [WIDTH-1:0]           push_data,
   input  logic                       pop,
   input  logic                       flush,
   output logic [$clog2(DEPTH):0]     count,
   output logic                       head_valid,
   output logic [WIDTH-1:0]           head_data
);

   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;

   logic [WIDTH-1:0] mem [DEPTH];
   logic [PW-1:0]    rd_ptr;
   logic [PW-1:0]    wr_ptr;
   logic             do_pop;

   assign head_valid = (count != '0);
   assign do_pop     = pop && head_valid;
   assign head_data  = head_valid ? mem[rd_ptr] : '0;

   // Pointers are exactly PW bits wide, so DEPTH being a power of two makes
   // them wrap on their own; count is what tells full from empty.
   always_ff @(negedge clk or negedge reset) begin
      if (!reset) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         count  <= '0;
      end else if (flush) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         count  <= '0;
      end else begin
         if (push)   wr_ptr <= wr_ptr + PW'(1);
         if (do_pop) rd_ptr <= rd_ptr + PW'(1);
         count <= count + CW'(push) - CW'(do_pop);
      end
   end

   // Storage carries no reset; stale slots are never visible because
   // head_data is gated by head_valid.
   always_ff @(negedge clk) begin
      if (push && !flush) mem[wr_ptr] <= push_data;
   end

endmodule : fetch_fifo

// File: rtl/fetch_queue_unit.sv
// -----------------------------------------------------------------------------
// fetch_queue_unit
//   Instruction-fetch stage: owns the PC, issues one request per cycle to a
//   1-cycle-latency instruction memory and queues {pc, inst} pairs for decode.
//   A taken branch flushes the queue and the in-flight fetch.
//   Ports:
//     clk           in   clock, state updates on the falling edge
//     reset         in   asynchronous active-low reset
//     branch_pc     in   redirect target
//     branch_taken  in   redirect strobe
//     imem_req      out  fetch request this cycle
//     imem_addr     out  fetch address (current pc)
//     imem_rdata    in   instruction, valid the cycle after imem_req
//     inst_valid    out  queue head valid
//     inst_ready    in   decode accepts head
//     inst          out  head instruction
//     inst_pc       out  head PC
//     fq_count      out  queue occupancy
//   Handshake: the head moves to decode on an edge where inst_valid and
//   inst_ready are both 1; inst_valid never depends on inst_ready, and while
//   inst_valid is 0 inst_ready has no effect.
// -----------------------------------------------------------------------------
module fetch_queue_unit
   import tinyrisc_pkg::*;
#(
   parameter int              XLEN       = DEF_XLEN,
   parameter logic [XLEN-1:0] RESET_PC   = XLEN'(DEF_RESET_PC),
   parameter int              FQ_DEPTH   = DEF_FQ_DEPTH,
   parameter int              INST_BYTES = DEF_INST_BYTES
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic [XLEN-1:0]           branch_pc,
   input  logic                      branch_taken,
   output logic                      imem_req,
   output logic [XLEN-1:0]           imem_addr,
   input  logic [XLEN-1:0]           imem_rdata,
   output logic                      inst_valid,
   input  logic                      inst_ready,
   output logic [XLEN-1:0]           inst,
   output logic [XLEN-1:0]           inst_pc,
   output logic [$clog2(FQ_DEPTH):0] fq_count
);

   localparam int              CW         = $clog2(FQ_DEPTH) + 1;
   localparam logic [XLEN-1:0] ALIGN_MASK = ~(XLEN'(INST_BYTES - 1));

   logic            [XLEN-1:0] pc;
   logic                       inflight_v;
   logic            [XLEN-1:0] inflight_pc;
   logic            [CW:0]     occupancy;
   logic                       push;
   logic                       pop;
   logic          [2*XLEN-1:0] head_data;

   // Credit counts queued entries plus the response still on its way back.
   // A pop on this same edge is deliberately not credited, so a push can
   // never find the queue full.
   assign occupancy = {1'b0, fq_count} + (CW+1)'(inflight_v);
   assign imem_req  = reset && !branch_taken && (occupancy < (CW+1)'(FQ_DEPTH));
   assign imem_addr = pc;

   assign push = inflight_v && !branch_taken;
   assign pop  = inst_valid && inst_ready;

   always_ff @(negedge clk or negedge reset) begin
      if (!reset) begin
         pc          <= RESET_PC;
         inflight_v  <= 1'b0;
         inflight_pc <= '0;
      end else begin
         // imem_req is already 0 during a redirect, so this also drops the
         // in-flight fetch on a branch.
         inflight_v <= imem_req;
         if (imem_req) inflight_pc <= pc;
         if (branch_taken)  pc <= branch_pc & ALIGN_MASK;
         else if (imem_req) pc <= pc + XLEN'(INST_BYTES);
      end
   end

   fetch_fifo #(
      .DEPTH (FQ_DEPTH),
      .WIDTH (2*XLEN)
   ) u_fifo (
      .clk        (clk),
      .reset      (reset),
      .push       (push),
      .push_data  ({inflight_pc, imem_rdata}),
      .pop        (pop),
      .flush      (branch_taken),
      .count      (fq_count),
      .head_valid (inst_valid),
      .head_data  (head_data)
   );

   assign inst_pc = head_data[2*XLEN-1:XLEN];
   assign inst    = head_data[XLEN-1:0];

endmodule : fetch_queue_unit

// File: tb/tb_fetch_queue_unit.sv
module tb_fetch_queue_unit;

   localparam int          XLEN     = 32;
   localparam int          FQ_DEPTH = 4;
   localparam logic [31:0] RESET_PC = 32'h0;

   // ---------------- clock / reset ----------------
   logic            clk = 1'b0;
   logic            reset = 1'b0;
   logic [XLEN-1:0] branch_pc = '0;
   logic            branch_taken = 1'b0;
   logic            imem_req;
   logic [XLEN-1:0] imem_addr;
   logic [XLEN-1:0] imem_rdata = '0;
   logic            inst_valid;
   logic            inst_ready = 1'b0;
   logic [XLEN-1:0] inst;
   logic [XLEN-1:0] inst_pc;
   logic [2:0]      fq_count;

   always #5 clk = ~clk;   // rising edges at 5,15,..; DUT acts on falling edges

   fetch_queue_unit #(
      .XLEN       (XLEN),
      .RESET_PC   (RESET_PC),
      .FQ_DEPTH   (FQ_DEPTH),
      .INST_BYTES (4)
   ) dut (
      .clk          (clk),
      .reset        (reset),
      .branch_pc    (branch_pc),
      .branch_taken (branch_taken),
      .imem_req     (imem_req),
      .imem_addr    (imem_addr),
      .imem_rdata   (imem_rdata),
      .inst_valid   (inst_valid),
      .inst_ready   (inst_ready),
      .inst         (inst),
      .inst_pc      (inst_pc),
      .fq_count     (fq_count)
   );

   // ---------------- scoreboard / reference model ----------------
   int n_checks = 0;
   int n_pass   = 0;

   logic [2*XLEN-1:0] exp_q[$];     // expected queue contents, {pc, inst}
   logic [XLEN-1:0]   m_pc;
   logic              m_infl;
   logic [XLEN-1:0]   m_infl_pc;
   logic [XLEN-1:0]   hs_q[$];      // inst_pc of every observed handshake

   logic              last_req_v = 1'b0;
   logic [XLEN-1:0]   last_req_addr = '0;

   function automatic logic [XLEN-1:0] mem_f(input logic [XLEN-1:0] a);
      return a | 32'h0000_A000;
   endfunction

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      else n_pass++;
   endtask

   task automatic model_reset();
      exp_q.delete();
      m_pc       = RESET_PC;
      m_infl     = 1'b0;
      m_infl_pc  = '0;
      last_req_v = 1'b0;
   endtask

   // ---------------- driver tasks ----------------
   // Asserts reset right away (callers are between edges), checks the reset
   // values immediately, then releases just after a falling edge.
   task automatic apply_reset();
      reset = 1'b0;
      #1;
      check("rst_imem_req",   imem_req,   0);
      check("rst_inst_valid", inst_valid, 0);
      check("rst_fq_count",   fq_count,   0);
      check("rst_inst",       inst,       0);
      check("rst_inst_pc",    inst_pc,    0);
      check("rst_imem_addr",  imem_addr,  RESET_PC);
      model_reset();
      @(negedge clk);
      @(negedge clk);
      #2;
      branch_taken = 1'b0;
      reset = 1'b1;
   endtask

   // One clock cycle: drive inputs after the rising edge, compare every output
   // with the model, then advance the model across the falling edge.
   task automatic step(input logic bt, input logic [XLEN-1:0] bpc, input logic rdy);
      logic              exp_req;
      logic [2*XLEN-1:0] head;
      int                occ;
      @(posedge clk);
      branch_taken = bt;
      branch_pc    = bpc;
      inst_ready   = rdy;
      imem_rdata   = last_req_v ? mem_f(last_req_addr) : XLEN'($urandom());
      #1;
      occ     = exp_q.size() + (m_infl ? 1 : 0);
      exp_req = !bt && (occ < FQ_DEPTH);
      head    = (exp_q.size() != 0) ? exp_q[0] : '0;
      check("imem_req",   imem_req,   exp_req);
      check("imem_addr",  imem_addr,  m_pc);
      check("inst_valid", inst_valid, exp_q.size() != 0);
      check("fq_count",   fq_count,   exp_q.size());
      check("inst_pc",    inst_pc,    head[2*XLEN-1:XLEN]);
      check("inst",       inst,       head[XLEN-1:0]);
      last_req_v    = imem_req;
      last_req_addr = imem_addr;
      if (inst_valid && inst_ready) hs_q.push_back(inst_pc);

      if (bt) begin
         exp_q.delete();
         m_infl = 1'b0;
         m_pc   = bpc & ~32'h3;
      end else begin
         if (exp_q.size() != 0 && rdy) void'(exp_q.pop_front());
         if (m_infl) exp_q.push_back({m_infl_pc, mem_f(m_infl_pc)});
         if (exp_req) begin
            m_infl    = 1'b1;
            m_infl_pc = m_pc;
            m_pc      = m_pc + 32'd4;
         end else begin
            m_infl = 1'b0;
         end
      end
      @(negedge clk);
      #1;
      branch_taken = 1'b0;
   endtask

   task automatic run(input int n, input logic rdy);
      for (int i = 0; i < n; i++) step(1'b0, '0, rdy);
   endtask

   // ---------------- test sequence ----------------
   initial begin
      model_reset();
      #1;
      apply_reset();

      // Streaming from reset: one instruction per cycle after the 2-edge fill.
      hs_q.delete();
      run(8, 1'b1);
      check("t1_hs_count", hs_q.size(), 6);
      check("t1_pc0", hs_q[0], 32'h0);
      check("t1_pc1", hs_q[1], 32'h4);
      check("t1_pc2", hs_q[2], 32'h8);

      // Decode stalled: queue saturates, fetch stops at pc 0x10, nothing lost.
      apply_reset();
      hs_q.delete();
      run(10, 1'b0);
      check("t2_full_count", fq_count, 4);
      check("t2_full_req",   imem_req, 0);
      check("t2_full_addr",  imem_addr, 32'h10);
      check("t2_full_valid", inst_valid, 1);
      run(6, 1'b1);
      check("t2_pc0", hs_q[0], 32'h0);
      check("t2_pc1", hs_q[1], 32'h4);
      check("t2_pc2", hs_q[2], 32'h8);
      check("t2_pc3", hs_q[3], 32'hC);
      check("t2_pc4", hs_q[4], 32'h10);

      // Redirect with 3 queued and one fetch in flight.
      apply_reset();
      run(4, 1'b0);
      check("t3_pre_count", fq_count, 3);
      step(1'b1, 32'h40, 1'b0);
      check("t3_flush_count", fq_count, 0);
      hs_q.delete();
      run(5, 1'b1);
      check("t3_pc0", hs_q[0], 32'h40);
      check("t3_pc1", hs_q[1], 32'h44);

      // Misaligned target, then back-to-back redirects.
      step(1'b1, 32'h43, 1'b1);
      check("t4_aligned_addr", imem_addr, 32'h40);
      run(3, 1'b1);
      step(1'b1, 32'h80, 1'b1);
      step(1'b1, 32'h100, 1'b1);
      hs_q.delete();
      run(5, 1'b1);
      check("t4_last_wins", hs_q[0], 32'h100);

      // PC wrap at the top of the address space.
      step(1'b1, 32'hFFFF_FFFC, 1'b1);
      hs_q.delete();
      run(5, 1'b1);
      check("t5_pc_top",  hs_q[0], 32'hFFFF_FFFC);
      check("t5_pc_wrap", hs_q[1], 32'h0);

      // Push and pop on the same edge keep the occupancy.
      apply_reset();
      run(4, 1'b0);
      step(1'b0, '0, 1'b1);
      check("t5_pushpop_count", fq_count, 3);

      // Reset between edges while full, then resume at RESET_PC.
      run(6, 1'b0);
      check("t6_full_count", fq_count, 4);
      #2;
      apply_reset();
      hs_q.delete();
      run(4, 1'b1);
      check("t6_resume_pc", hs_q[0], RESET_PC);

      // Randomized traffic against the model.
      for (int i = 0; i < 600; i++) begin
         logic            bt;
         logic [XLEN-1:0] bpc;
         bt  = ($urandom_range(0, 15) == 0);
         bpc = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 | XLEN'($urandom_range(0, 15)))
                                           : XLEN'($urandom());
         step(bt, bpc, ($urandom_range(0, 3) != 0));
         if ($urandom_range(0, 199) == 0) apply_reset();
      end

      // ---------------- final report ----------------
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule : tb_fetch_queue_unit
